// File: rtl/alu_mc.sv
`default_nettype none
// ============================================================================
// Module   : alu_mc
// Purpose  : Multi-cycle ALU with a valid/ready handshake on both sides.
//            Single-cycle ops: add, sub, or, and, slt (signed), xor.
//            Multiply: iterative shift-add, one multiplier bit per cycle,
//            WIDTH cycles from accept to result. Results are registered and
//            held stable until the consumer takes them.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH        operand / result width in bits (2..64)
//   MUL_EN       1 = multiply supported, 0 = opcode 100 is illegal
// Ports
//   clk_i        clock, rising edge
//   rst_n        asynchronous active-low reset
//   flush_i      synchronous abort of any in-flight or held operation
//   in_valid_i   request valid
//   in_ready_o   request can be accepted this cycle (combinational)
//   data1_i      operand A
//   data2_i      operand B
//   ALUCtr_i     opcode: 000 add, 001 sub, 010 or, 011 and, 100 mul,
//                        101 slt, 110 xor, 111 illegal
//   out_valid_o  result valid
//   out_ready_i  consumer takes the result
//   dataout_o    registered result
//   zero_o       registered, 1 when dataout_o == 0
//   err_o        registered, 1 when the opcode was illegal
// ============================================================================
module alu_mc #(
   parameter int WIDTH  = 32,
   parameter int MUL_EN = 1
) (
   input  logic             clk_i,
   input  logic             rst_n,
   input  logic             flush_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] data1_i,
   input  logic [WIDTH-1:0] data2_i,
   input  logic [2:0]       ALUCtr_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] dataout_o,
   output logic             zero_o,
   output logic             err_o
);

   // ------------------------------------------------------------------------
   // Constants
   // ------------------------------------------------------------------------
   localparam int             c_cnt_w     = $clog2(WIDTH);
   // Counter stops at WIDTH-1, so it never wraps inside one multiply.
   localparam logic [c_cnt_w-1:0] c_last_step = c_cnt_w'(WIDTH - 1);
   localparam logic           c_mul_en    = (MUL_EN != 0);

   localparam logic [2:0]     c_op_add    = 3'b000;
   localparam logic [2:0]     c_op_sub    = 3'b001;
   localparam logic [2:0]     c_op_or     = 3'b010;
   localparam logic [2:0]     c_op_and    = 3'b011;
   localparam logic [2:0]     c_op_mul    = 3'b100;
   localparam logic [2:0]     c_op_slt    = 3'b101;
   localparam logic [2:0]     c_op_xor    = 3'b110;
   localparam logic [2:0]     c_op_ill    = 3'b111;

   // ------------------------------------------------------------------------
   // State machine encoding
   // ------------------------------------------------------------------------
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_state_next;

   // ------------------------------------------------------------------------
   // Registers and wires
   // ------------------------------------------------------------------------
   logic [WIDTH-1:0]     r_dataout;
   logic                 r_zero;
   logic                 r_err;
   logic [WIDTH-1:0]     r_mcand;      // multiplicand, shifts left each step
   logic [WIDTH-1:0]     r_mplier;     // multiplier, shifts right each step
   logic [WIDTH-1:0]     r_acc;        // partial product (low WIDTH bits)
   logic [c_cnt_w-1:0]   r_cnt;        // multiply step counter

   logic                 w_in_ready;
   logic                 w_accept;
   logic                 w_is_mul;
   logic                 w_illegal;
   logic                 w_slt;
   logic                 w_last_step;
   logic [WIDTH-1:0]     w_alu_res;
   logic [WIDTH-1:0]     w_acc_next;

   // ------------------------------------------------------------------------
   // Opcode decode
   // ------------------------------------------------------------------------
   assign w_is_mul    = (ALUCtr_i == c_op_mul) && c_mul_en;
   assign w_illegal   = (ALUCtr_i == c_op_ill) ||
                        ((ALUCtr_i == c_op_mul) && !c_mul_en);
   assign w_slt       = ($signed(data1_i) < $signed(data2_i));

   // Single-cycle result. Multiply and illegal opcodes fall to the default,
   // which gives the all-zero result required for illegal operations.
   always_comb begin
      w_alu_res = '0;
      case (ALUCtr_i)
         c_op_add: w_alu_res = data1_i + data2_i;
         c_op_sub: w_alu_res = data1_i - data2_i;
         c_op_or:  w_alu_res = data1_i | data2_i;
         c_op_and: w_alu_res = data1_i & data2_i;
         c_op_slt: w_alu_res = {{(WIDTH-1){1'b0}}, w_slt};
         c_op_xor: w_alu_res = data1_i ^ data2_i;
         default:  w_alu_res = '0;
      endcase
   end

   // One shift-add step: add the shifted multiplicand when the current
   // multiplier LSB is set. Carries above WIDTH are discarded, which yields
   // exactly the low WIDTH bits of the unsigned product.
   assign w_acc_next  = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
   assign w_last_step = (r_cnt == c_last_step);

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: next state and handshake
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      w_in_ready   = 1'b0;

      // A held result frees the block in the same cycle it is consumed,
      // which allows back-to-back operations without a bubble.
      case (r_state)
         IDLE:    w_in_ready = 1'b1;
         DONE:    w_in_ready = out_ready_i;
         default: w_in_ready = 1'b0;
      endcase
      if (flush_i) begin
         w_in_ready = 1'b0;
      end

      w_accept = in_valid_i && w_in_ready;

      if (flush_i) begin
         w_state_next = IDLE;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  w_state_next = w_is_mul ? MUL : DONE;
               end
            end
            MUL: begin
               if (w_last_step) begin
                  w_state_next = DONE;
               end
            end
            DONE: begin
               if (w_accept) begin
                  w_state_next = w_is_mul ? MUL : DONE;
               end else if (out_ready_i) begin
                  w_state_next = IDLE;
               end
            end
            default: w_state_next = IDLE;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Datapath: operand capture, multiply iteration and result registers.
   // Result registers only change on a single-cycle accept or on the final
   // multiply step, so they stay stable while a result is being held.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         r_dataout <= '0;
         r_zero    <= 1'b0;
         r_err     <= 1'b0;
         r_mcand   <= '0;
         r_mplier  <= '0;
         r_acc     <= '0;
         r_cnt     <= '0;
      end else if (flush_i) begin
         // Abandon any multiply; the last presented result stays visible
         // on the data outputs but is no longer flagged valid.
         r_mcand   <= '0;
         r_mplier  <= '0;
         r_acc     <= '0;
         r_cnt     <= '0;
      end else if (w_accept) begin
         if (w_is_mul) begin
            r_mcand  <= data1_i;
            r_mplier <= data2_i;
            r_acc    <= '0;
            r_cnt    <= '0;
         end else begin
            r_dataout <= w_alu_res;
            r_zero    <= (w_alu_res == '0);
            r_err     <= w_illegal;
         end
      end else if (r_state == MUL) begin
         r_acc    <= w_acc_next;
         r_mcand  <= {r_mcand[WIDTH-2:0], 1'b0};
         r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
         if (w_last_step) begin
            r_dataout <= w_acc_next;
            r_zero    <= (w_acc_next == '0);
            r_err     <= 1'b0;
            r_cnt     <= '0;
         end else begin
            r_cnt     <= r_cnt + c_cnt_w'(1);
         end
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign in_ready_o  = w_in_ready;
   assign out_valid_o = (r_state == DONE);
   assign dataout_o   = r_dataout;
   assign zero_o      = r_zero;
   assign err_o       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_mc
// Purpose  : Self-checking bench for alu_mc (WIDTH=32). A transaction-level
//            reference tracks what the consumer must observe each cycle;
//            directed vectors add hand-computed literal expectations.
//            A second instance with MUL_EN=0 covers illegal-opcode handling.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_mc;

   localparam int W = 32;

   // Stimulus changes only on falling edges; checks run #1 after rising
   // edges (outputs) or #1 after falling edges (combinational ready).
   logic          clk       = 1'b0;
   logic          rst_n     = 1'b0;
   logic          flush     = 1'b0;
   logic          in_valid  = 1'b0;
   logic          out_ready = 1'b1;
   logic [2:0]    op        = 3'b000;
   logic [W-1:0]  a         = '0;
   logic [W-1:0]  b         = '0;
   logic          in_ready;
   logic          out_valid;
   logic          zero;
   logic          err;
   logic [W-1:0]  dout;

   logic          in_valid0 = 1'b0;
   logic [2:0]    op0       = 3'b000;
   logic [W-1:0]  a0        = '0;
   logic [W-1:0]  b0        = '0;
   logic          in_ready0;
   logic          out_valid0;
   logic          zero0;
   logic          err0;
   logic [W-1:0]  dout0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_mc #(.WIDTH(W), .MUL_EN(1)) dut (
      .clk_i       (clk),
      .rst_n       (rst_n),
      .flush_i     (flush),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .data1_i     (a),
      .data2_i     (b),
      .ALUCtr_i    (op),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .dataout_o   (dout),
      .zero_o      (zero),
      .err_o       (err)
   );

   alu_mc #(.WIDTH(W), .MUL_EN(0)) dut0 (
      .clk_i       (clk),
      .rst_n       (rst_n),
      .flush_i     (1'b0),
      .in_valid_i  (in_valid0),
      .in_ready_o  (in_ready0),
      .data1_i     (a0),
      .data2_i     (b0),
      .ALUCtr_i    (op0),
      .out_valid_o (out_valid0),
      .out_ready_i (1'b1),
      .dataout_o   (dout0),
      .zero_o      (zero0),
      .err_o       (err0)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", name, act, exp);
      end
   endtask

   // ------------------------------------------------------------------------
   // Reference: plain arithmetic on the request, plus a countdown for the
   // multiply latency and a flag for "result presented to the consumer".
   // ------------------------------------------------------------------------
   function automatic logic [W-1:0] ref_result(input logic [2:0] o,
                                               input logic [W-1:0] x,
                                               input logic [W-1:0] y);
      case (o)
         3'd0:    return x + y;
         3'd1:    return x - y;
         3'd2:    return x | y;
         3'd3:    return x & y;
         3'd4:    return x * y;
         3'd5:    return ($signed(x) < $signed(y)) ? 1 : 0;
         3'd6:    return x ^ y;
         default: return '0;
      endcase
   endfunction

   int            m_busy  = 0;     // edges remaining until a multiply result
   logic          m_valid = 1'b0;  // a result is being presented
   logic [W-1:0]  m_data  = '0;
   logic          m_zero  = 1'b0;
   logic          m_err   = 1'b0;
   logic [W-1:0]  m_pend  = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy  <= 0;
         m_valid <= 1'b0;
         m_data  <= '0;
         m_zero  <= 1'b0;
         m_err   <= 1'b0;
         m_pend  <= '0;
      end else if (flush) begin
         m_busy  <= 0;
         m_valid <= 1'b0;
      end else if (m_busy != 0) begin
         m_busy <= m_busy - 1;
         if (m_busy == 1) begin
            m_valid <= 1'b1;
            m_data  <= m_pend;
            m_zero  <= (m_pend == 0);
            m_err   <= 1'b0;
         end
      end else if (in_valid && (!m_valid || out_ready)) begin
         if (op == 3'd4) begin
            m_busy  <= W;
            m_valid <= 1'b0;
            m_pend  <= ref_result(op, a, b);
         end else begin
            m_valid <= 1'b1;
            m_data  <= ref_result(op, a, b);
            m_zero  <= (ref_result(op, a, b) == 0);
            m_err   <= (op == 3'd7);
         end
      end else if (m_valid && out_ready) begin
         m_valid <= 1'b0;
      end
   end

   always @(posedge clk) begin
      #1;
      if (rst_n) begin
         chk("ref out_valid", out_valid, m_valid);
         chk("ref in_ready", in_ready,
             !flush && (m_busy == 0) && (!m_valid || out_ready));
         if (m_valid) begin
            chk("ref dataout", dout, m_data);
            chk("ref zero", zero, m_zero);
            chk("ref err", err, m_err);
         end
      end
   end

   // ------------------------------------------------------------------------
   // Stimulus helpers
   // ------------------------------------------------------------------------
   // Present a request and return just after the edge that accepts it.
   task automatic send(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      int n;
      @(negedge clk);
      in_valid = 1'b1;
      op = o;
      a = x;
      b = y;
      #1;
      n = 0;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("request accepted in time", in_ready, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   initial begin
      int lowcnt;
      int early;
      int n;
      int vcnt;

      // Reset state
      #3;
      chk("reset out_valid", out_valid, 0);
      chk("reset dataout", dout, 0);
      chk("reset zero", zero, 0);
      chk("reset err", err, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("ready after reset", in_ready, 1);
      chk("ready after reset (mul off)", in_ready0, 1);

      // add wraps to zero
      send(3'd0, 32'hFFFF_FFFF, 32'd1);
      chk("add wrap valid", out_valid, 1);
      chk("add wrap data", dout, 0);
      chk("add wrap zero", zero, 1);
      chk("add wrap err", err, 0);

      // signed compare and subtract wrap (back-to-back)
      send(3'd5, 32'hFFFF_FFFF, 32'd1);
      chk("slt -1<1", dout, 1);
      send(3'd1, 32'd0, 32'd1);
      chk("sub 0-1 data", dout, 32'hFFFF_FFFF);
      chk("sub 0-1 zero", zero, 0);
      idle();
      @(posedge clk);
      #1;
      chk("consumed -> valid low", out_valid, 0);
      chk("consumed -> data kept", dout, 32'hFFFF_FFFF);

      // multiply 7 x 6: 32 busy cycles
      send(3'd4, 32'd7, 32'd6);
      lowcnt = 0;
      early = 0;
      for (int k = 1; k <= W; k++) begin
         @(negedge clk);
         in_valid = 1'b0;
         #1;
         if (!in_ready) lowcnt++;
         @(posedge clk);
         #1;
         if (k < W && out_valid) early++;
      end
      chk("mul busy cycles", lowcnt, 32);
      chk("mul early valid", early, 0);
      chk("mul 7x6 valid", out_valid, 1);
      chk("mul 7x6 data", dout, 42);

      // multiply overflow to zero, with a held add request during the multiply
      send(3'd4, 32'h0001_0000, 32'h0001_0000);
      @(negedge clk);
      op = 3'd0;
      a = 32'd1;
      b = 32'd1;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!out_valid && n < 40);
      chk("mul latency", n, 32);
      chk("mul 2^32 data", dout, 0);
      chk("mul 2^32 zero", zero, 1);
      @(posedge clk);
      #1;
      chk("held add back-to-back valid", out_valid, 1);
      chk("held add back-to-back data", dout, 2);
      idle();

      // consumer stall, then back-to-back xor
      @(negedge clk);
      out_ready = 1'b0;
      send(3'd2, 32'hF0, 32'h0F);
      chk("or data", dout, 32'hFF);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         in_valid = 1'b0;
         #1;
         chk("stall in_ready", in_ready, 0);
         @(posedge clk);
         #1;
         chk("stall held valid", out_valid, 1);
         chk("stall held data", dout, 32'hFF);
      end
      @(negedge clk);
      out_ready = 1'b1;
      in_valid = 1'b1;
      op = 3'd6;
      a = 32'd3;
      b = 32'd1;
      #1;
      chk("release in_ready", in_ready, 1);
      @(posedge clk);
      #1;
      chk("xor back-to-back valid", out_valid, 1);
      chk("xor back-to-back data", dout, 2);

      // flush at step 10 of a multiply, with a competing request
      send(3'd4, 32'd5, 32'd3);
      repeat (10) @(posedge clk);
      @(negedge clk);
      flush = 1'b1;
      in_valid = 1'b1;
      op = 3'd0;
      a = 32'd9;
      b = 32'd9;
      #1;
      chk("flush blocks ready", in_ready, 0);
      @(posedge clk);
      #1;
      chk("flush valid low", out_valid, 0);
      @(negedge clk);
      flush = 1'b0;
      in_valid = 1'b0;
      send(3'd3, 32'hC, 32'hA);
      chk("and after flush", dout, 8);
      idle();
      vcnt = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk);
         #1;
         if (out_valid) vcnt++;
      end
      chk("no flushed mul result", vcnt, 0);

      // asynchronous reset in the middle of a multiply
      send(3'd4, 32'd7, 32'd6);
      repeat (5) @(posedge clk);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async rst out_valid", out_valid, 0);
      chk("async rst dataout", dout, 0);
      chk("async rst zero", zero, 0);
      chk("async rst err", err, 0);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("ready after mid-mul reset", in_ready, 1);
      vcnt = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk);
         #1;
         if (out_valid) vcnt++;
      end
      chk("no result after reset", vcnt, 0);
      send(3'd0, 32'd2, 32'd3);
      chk("add after reset", dout, 5);
      idle();

      // MUL_EN = 0: opcode 100 and 111 are illegal, one-cycle latency
      @(negedge clk);
      in_valid0 = 1'b1;
      op0 = 3'd4;
      a0 = 32'd7;
      b0 = 32'd6;
      #1;
      chk("mul-off ready", in_ready0, 1);
      @(posedge clk);
      #1;
      chk("mul-off op100 valid", out_valid0, 1);
      chk("mul-off op100 data", dout0, 0);
      chk("mul-off op100 zero", zero0, 1);
      chk("mul-off op100 err", err0, 1);
      @(negedge clk);
      op0 = 3'd7;
      a0 = 32'd5;
      b0 = 32'd5;
      @(posedge clk);
      #1;
      chk("op111 valid", out_valid0, 1);
      chk("op111 data", dout0, 0);
      chk("op111 zero", zero0, 1);
      chk("op111 err", err0, 1);
      @(negedge clk);
      op0 = 3'd0;
      a0 = 32'd2;
      b0 = 32'd3;
      @(posedge clk);
      #1;
      chk("mul-off add data", dout0, 5);
      chk("mul-off add err", err0, 0);
      chk("mul-off add zero", zero0, 0);
      @(negedge clk);
      in_valid0 = 1'b0;
      @(posedge clk);
      #1;
      chk("mul-off idle valid", out_valid0, 0);

      repeat (2) @(posedge clk);
      #2;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

endmodule
`default_nettype wire

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits; legal range 2..64.
REQ-002 Parameter MUL_EN, default 1; 1 = multiply supported, 0 = multiply opcode treated as illegal.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 flush_i  input  1  synchronous abort of any in-flight or held operation.
REQ-006 in_valid_i  input  1  operation request valid.
REQ-007 in_ready_o  output  1  block can accept a request this cycle.
REQ-008 data1_i  input  WIDTH  operand A.
REQ-009 data2_i  input  WIDTH  operand B.
REQ-010 ALUCtr_i  input  3  opcode: 000 add, 001 sub, 010 or, 011 and, 100 mul, 101 slt (signed), 110 xor, 111 illegal.
REQ-011 out_valid_o  output  1  result valid.
REQ-012 out_ready_i  input  1  consumer accepts result.
REQ-013 dataout_o  output  WIDTH  registered result.
REQ-014 zero_o  output  1  registered; 1 when dataout_o == 0.
REQ-015 err_o  output  1  registered; 1 when the opcode was illegal.

Function
REQ-016 FSM states SHALL be IDLE, MUL, DONE.
REQ-017 in_ready_o SHALL be combinational: (IDLE or (DONE and out_ready_i)) and not flush_i.
REQ-018 Accept = in_valid_i and in_ready_o at a rising edge; operands and opcode captured only on accept.
REQ-019 Non-multiply accept: result, zero, err registered at the accept edge; state to DONE; latency 1 cycle.
REQ-020 add/sub/or/and/xor SHALL wrap modulo 2^WIDTH; no carry/overflow output.
REQ-021 slt SHALL produce 1 (zero-extended) when data1 < data2 as signed two's complement, else 0.
REQ-022 mul (MUL_EN=1) SHALL produce low WIDTH bits of the unsigned product via iterative shift-add, one multiplier bit per cycle.
REQ-023 mul accept: state to MUL, step counter cleared; WIDTH steps on the following WIDTH edges; state to DONE on the last step; out_valid_o high after edge accept+WIDTH.
REQ-024 Illegal opcode (111, or 100 with MUL_EN=0): dataout_o = 0, zero_o = 1, err_o = 1, 1-cycle latency.
REQ-025 out_valid_o SHALL equal (state == DONE); dataout_o/zero_o/err_o SHALL hold stable while out_valid_o and not out_ready_i.
REQ-026 DONE with out_ready_i and no accept: state to IDLE; outputs keep last values, out_valid_o low.
REQ-027 DONE with out_ready_i and accept in same cycle: new op starts with no bubble (back-to-back).
REQ-028 flush_i high at an edge: state to IDLE, out_valid_o low next cycle, multiply abandoned, no accept that cycle; flush wins over all other events.
REQ-029 in_valid_i while in MUL or held DONE SHALL be ignored (in_ready_o low); requester must hold request.
REQ-030 Step counter SHALL be clog2(WIDTH) bits and SHALL not wrap within one multiply.

Reset
REQ-031 rst_n low SHALL immediately force state IDLE, out_valid_o 0, dataout_o 0, zero_o 0, err_o 0, counter and multiply registers 0, irrespective of clock.
REQ-032 Reset asserted mid-multiply SHALL discard the operation; no result is ever presented for it.
REQ-033 After rst_n deassertion with flush_i low, in_ready_o SHALL be 1.

Verification (WIDTH=32, MUL_EN=1 unless stated)
REQ-034 add 0xFFFFFFFF + 1, out_ready high -> next cycle out_valid 1, dataout 0, zero 1, err 0.
REQ-035 slt 0xFFFFFFFF, 1 -> dataout 1; sub 0, 1 -> dataout 0xFFFFFFFF, zero 0.
REQ-036 mul 7 x 6 -> in_ready low for 32 cycles, out_valid after edge accept+32, dataout 42; mul 0x10000 x 0x10000 -> dataout 0.
REQ-037 out_ready low 5 cycles after or 0xF0 | 0x0F -> dataout 0xFF held 5 cycles, in_ready low; then out_ready high with in_valid xor 3,1 -> back-to-back, next dataout 2.
REQ-038 flush at step 10 of a mul, then and 0xC, 0xA -> no mul result emitted, next dataout 8; repeat with rst_n pulse mid-mul -> all outputs 0 immediately.
REQ-039 MUL_EN=0, opcode 100 and opcode 111 -> dataout 0, zero 1, err 1, 1-cycle latency.
